// File: rtl/tx_fifo_param.sv
// Parameterised first-word-fall-through transmit FIFO with threshold flags and synchronous flush.
// Define TX_FIFO_ERR_FLAGS_EN to add the sticky overflow/underflow outputs.
module tx_fifo_param #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     flush,
  input  logic                     write_enable,
  input  logic [DATA_WIDTH-1:0]    write_data,
  input  logic                     read_enable,
  output logic [DATA_WIDTH-1:0]    read_data,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count
`ifdef TX_FIFO_ERR_FLAGS_EN
  ,
  output logic                     overflow,
  output logic                     underflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_CNT = CW'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic                  do_push;
  logic                  do_pop;

  // A pop frees a slot on the same edge, so a full FIFO still accepts a push alongside it.
  assign do_pop  = read_enable && !fifo_empty;
  assign do_push = write_enable && (!fifo_full || do_pop);

  assign fifo_empty   = (count == '0);
  assign fifo_full    = (count == FULL_CNT);
  assign almost_full  = (count >= AFULL_CNT);
  assign almost_empty = (count <= AEMPTY_CNT);
  assign read_data    = fifo_empty ? '0 : mem[rptr];

  // Storage: data only, never cleared.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wptr] <= write_data;
    end
  end

  // Control: pointers and occupancy.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + AW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef TX_FIFO_ERR_FLAGS_EN
  // Sticky error flags: held until flush or reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_enable && !do_push) begin
        overflow <= 1'b1;
      end
      if (read_enable && fifo_empty) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tx_fifo_param.sv
// Self-checking bench for tx_fifo_param: default instance plus a 12-bit, 4-deep instance,
// both compared against queue-based reference models.
module tb_tx_fifo_param;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic       fl, we, re;
  logic [7:0] wd, rd;
  logic       emp, ful, af, ae;
  logic [4:0] cnt;
  logic       ovf, unf;

  // Small instance: DATA_WIDTH=12, DEPTH=4
  logic        s_fl, s_we, s_re;
  logic [11:0] s_wd, s_rd;
  logic        s_emp, s_ful, s_af, s_ae;
  logic [2:0]  s_cnt;
  logic        s_ovf, s_unf;

  tx_fifo_param dut (
    .clk(clk), .n_rst(n_rst), .flush(fl), .write_enable(we), .write_data(wd),
    .read_enable(re), .read_data(rd), .fifo_empty(emp), .fifo_full(ful),
    .almost_full(af), .almost_empty(ae), .count(cnt)
`ifdef TX_FIFO_ERR_FLAGS_EN
    , .overflow(ovf), .underflow(unf)
`endif
  );

  tx_fifo_param #(.DATA_WIDTH(12), .DEPTH(4)) dut_s (
    .clk(clk), .n_rst(n_rst), .flush(s_fl), .write_enable(s_we), .write_data(s_wd),
    .read_enable(s_re), .read_data(s_rd), .fifo_empty(s_emp), .fifo_full(s_ful),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_cnt)
`ifdef TX_FIFO_ERR_FLAGS_EN
    , .overflow(s_ovf), .underflow(s_unf)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference models: occupancy is the queue itself.
  logic [7:0]  q[$];
  logic [11:0] sq[$];
  bit          m_ovf, m_unf, ms_ovf, ms_unf;
  int          s_pushes;

  task automatic model_clear();
    q.delete(); sq.delete();
    m_ovf = 0; m_unf = 0; ms_ovf = 0; ms_unf = 0;
  endtask

  task automatic model_update();
    bit pop, push;
    logic [7:0]  w;
    logic [11:0] sw;
    if (fl) begin
      q.delete(); m_ovf = 0; m_unf = 0;
    end else begin
      pop  = re && (q.size() > 0);
      push = we && ((q.size() < 16) || pop);
      if (we && !push) m_ovf = 1;
      if (re && q.size() == 0) m_unf = 1;
      if (pop) w = q.pop_front();
      if (push) q.push_back(wd);
    end
    if (s_fl) begin
      sq.delete(); ms_ovf = 0; ms_unf = 0;
    end else begin
      pop  = s_re && (sq.size() > 0);
      push = s_we && ((sq.size() < 4) || pop);
      if (s_we && !push) ms_ovf = 1;
      if (s_re && sq.size() == 0) ms_unf = 1;
      if (pop) sw = sq.pop_front();
      if (push) begin
        sq.push_back(s_wd);
        s_pushes++;
      end
    end
  endtask

  // Inputs are changed only at negedge; one call = one rising edge.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    fl = 0; we = 0; re = 0; wd = '0;
    s_fl = 0; s_we = 0; s_re = 0; s_wd = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    n_rst = 0;
    model_clear();
    #12;
    checks++;
    if (cnt !== 5'd0 || emp !== 1'b1 || ful !== 1'b0 || ae !== 1'b1 || af !== 1'b0 || rd !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: cnt=%0d emp=%b ful=%b ae=%b af=%b rd=%h, want 0 1 0 1 0 00", cnt, emp, ful, ae, af, rd);
    end
    checks++;
    if (s_cnt !== 3'd0 || s_emp !== 1'b1 || s_rd !== 12'h000) begin
      errors++;
      $display("FAIL reset_small: cnt=%0d emp=%b rd=%h, want 0 1 000", s_cnt, s_emp, s_rd);
    end
`ifdef TX_FIFO_ERR_FLAGS_EN
    checks++;
    if (ovf !== 1'b0 || unf !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: ovf=%b unf=%b, want 0 0", ovf, unf);
    end
`endif
    @(negedge clk);
    n_rst = 1;
    @(negedge clk);
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 16; i++) begin
      we = 1; wd = 8'(i);
      step();
      checks++;
      if (cnt !== 5'(i) || af !== (i >= 14) || ful !== (i == 16) || ae !== (i <= 2) || rd !== 8'h01) begin
        errors++;
        $display("FAIL fill_%0d: cnt=%0d af=%b ful=%b ae=%b rd=%h, want %0d %b %b %b 01",
                 i, cnt, af, ful, ae, rd, i, i >= 14, i == 16, i <= 2);
      end
    end
    we = 0;
    for (int i = 1; i <= 16; i++) begin
      checks++;
      if (rd !== 8'(i)) begin
        errors++;
        $display("FAIL drain_%0d: rd=%h want %h", i, rd, 8'(i));
      end
      re = 1;
      step();
    end
    re = 0;
    checks++;
    if (emp !== 1'b1 || cnt !== 5'd0 || rd !== 8'h00) begin
      errors++;
      $display("FAIL drain_end: emp=%b cnt=%0d rd=%h, want 1 0 00", emp, cnt, rd);
    end
  endtask

  task automatic test_full_swap();
    logic [7:0] old_head;
    for (int i = 0; i < 16; i++) begin
      we = 1; wd = 8'($urandom_range(0, 8'hA9));
      step();
    end
    old_head = q[0];
    checks++;
    if (ful !== 1'b1 || rd !== old_head) begin
      errors++;
      $display("FAIL swap_pre: ful=%b rd=%h, want 1 %h", ful, rd, old_head);
    end
    we = 1; wd = 8'hAA; re = 1;
    step();
    we = 0; re = 0;
    checks++;
    if (cnt !== 5'd16 || ful !== 1'b1 || rd !== q[0]) begin
      errors++;
      $display("FAIL swap_post: cnt=%0d ful=%b rd=%h, want 16 1 %h", cnt, ful, rd, q[0]);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rd !== q[0] || cnt !== 5'(q.size())) begin
        errors++;
        $display("FAIL swap_drain_%0d: rd=%h cnt=%0d, want %h %0d", i, rd, cnt, q[0], q.size());
      end
      if (i == 15) begin
        checks++;
        if (rd !== 8'hAA) begin
          errors++;
          $display("FAIL swap_last: rd=%h want aa", rd);
        end
      end
      re = 1;
      step();
    end
    re = 0;
  endtask

  task automatic test_empty_both();
    we = 1; wd = 8'h55; re = 1;
    step();
    we = 0; re = 0;
    checks++;
    if (cnt !== 5'd1 || rd !== 8'h55 || emp !== 1'b0) begin
      errors++;
      $display("FAIL empty_both: cnt=%0d rd=%h emp=%b, want 1 55 0", cnt, rd, emp);
    end
`ifdef TX_FIFO_ERR_FLAGS_EN
    checks++;
    if (unf !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL underflow_set: unf=%b ovf=%b, want 1 0", unf, ovf);
    end
`endif
    // Flush wins over concurrent push and pop.
    fl = 1; we = 1; wd = 8'h99; re = 1;
    step();
    fl = 0; we = 0; re = 0;
    checks++;
    if (cnt !== 5'd0 || emp !== 1'b1 || rd !== 8'h00) begin
      errors++;
      $display("FAIL flush_prio: cnt=%0d emp=%b rd=%h, want 0 1 00", cnt, emp, rd);
    end
`ifdef TX_FIFO_ERR_FLAGS_EN
    checks++;
    if (unf !== m_unf) begin
      errors++;
      $display("FAIL underflow_clr: unf=%b want %b", unf, m_unf);
    end
`endif
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 16; i++) begin
      we = 1; wd = 8'(8'h20 + i);
      step();
    end
    we = 1; wd = 8'h77;
    step();
    we = 0;
    checks++;
    if (cnt !== 5'd16 || rd !== 8'h21) begin
      errors++;
      $display("FAIL overflow_drop: cnt=%0d rd=%h, want 16 21", cnt, rd);
    end
`ifdef TX_FIFO_ERR_FLAGS_EN
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set: ovf=%b want 1", ovf);
    end
`endif
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rd === 8'h77 || rd !== q[0]) begin
        errors++;
        $display("FAIL overflow_drain_%0d: rd=%h want %h", i, rd, q[0]);
      end
      re = 1;
      step();
    end
    re = 0;
`ifdef TX_FIFO_ERR_FLAGS_EN
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: ovf=%b want 1", ovf);
    end
`endif
    fl = 1;
    step();
    fl = 0;
    checks++;
    if (cnt !== 5'd0 || emp !== 1'b1) begin
      errors++;
      $display("FAIL overflow_flush: cnt=%0d emp=%b, want 0 1", cnt, emp);
    end
`ifdef TX_FIFO_ERR_FLAGS_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clr: ovf=%b want 0", ovf);
    end
`endif
  endtask

  task automatic test_random_small();
    int n = 0;
    s_pushes = 0;
    while ((n < 40 || s_pushes < 20) && n < 200) begin
      s_we = ($urandom_range(0, 7) != 0);
      s_re = ($urandom_range(0, 7) != 0);
      s_wd = 12'($urandom);
      step();
      checks++;
      if (s_cnt !== 3'(sq.size()) || s_rd !== (sq.size() > 0 ? sq[0] : 12'h000) ||
          s_emp !== (sq.size() == 0) || s_ful !== (sq.size() == 4) ||
          s_af !== (sq.size() >= 2) || s_ae !== (sq.size() <= 2)) begin
        errors++;
        $display("FAIL rand_%0d: cnt=%0d rd=%h emp=%b ful=%b af=%b ae=%b, want cnt=%0d rd=%h",
                 n, s_cnt, s_rd, s_emp, s_ful, s_af, s_ae, sq.size(), sq.size() > 0 ? sq[0] : 12'h000);
      end
`ifdef TX_FIFO_ERR_FLAGS_EN
      checks++;
      if (s_ovf !== ms_ovf || s_unf !== ms_unf) begin
        errors++;
        $display("FAIL rand_err_%0d: ovf=%b unf=%b, want %b %b", n, s_ovf, s_unf, ms_ovf, ms_unf);
      end
`endif
      n++;
    end
    s_we = 0; s_re = 0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) begin
      we = 1; wd = 8'($urandom);
      step();
    end
    we = 0;
    checks++;
    if (cnt !== 5'd7) begin
      errors++;
      $display("FAIL midrst_pre: cnt=%0d want 7", cnt);
    end
    #2 n_rst = 0;
    #1;
    model_clear();
    checks++;
    if (cnt !== 5'd0 || emp !== 1'b1 || rd !== 8'h00) begin
      errors++;
      $display("FAIL midrst_async: cnt=%0d emp=%b rd=%h, want 0 1 00", cnt, emp, rd);
    end
    @(negedge clk);
    n_rst = 1;
    we = 1; wd = 8'h3C;
    step();
    we = 0;
    checks++;
    if (rd !== 8'h3C || cnt !== 5'd1) begin
      errors++;
      $display("FAIL midrst_push: rd=%h cnt=%0d, want 3c 1", rd, cnt);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_swap();
    test_empty_both();
    test_overflow();
    test_random_small();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_fifo_param.md
TX_FIFO_PARAM -- requirements
Module: tx_fifo_param

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, which sets the word width in bits (1..64).
REQ-002 The block SHALL have parameter DEPTH, default 16, which sets the number of storage words (power of 2, 2..256).
REQ-003 The block SHALL have parameter AFULL_THRESH, default DEPTH-2, where almost_full is asserted when count >= AFULL_THRESH.
REQ-004 The block SHALL have parameter AEMPTY_THRESH, default 2, where almost_empty is asserted when count <= AEMPTY_THRESH.
REQ-005 The block SHALL have port clk, input, width 1, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port n_rst, input, width 1, the asynchronous active-low reset.
REQ-007 The block SHALL have port flush, input, width 1, a synchronous clear of contents.
REQ-008 The block SHALL have port write_enable, input, width 1, a push request.
REQ-009 The block SHALL have port write_data, input, width DATA_WIDTH, the push word.
REQ-010 The block SHALL have port read_enable, input, width 1, a pop request.
REQ-011 The block SHALL have port read_data, output, width DATA_WIDTH, the head word.
REQ-012 The block SHALL have port fifo_empty, output, width 1, asserted when count==0.
REQ-013 The block SHALL have port fifo_full, output, width 1, asserted when count==DEPTH.
REQ-014 The block SHALL have ports almost_full and almost_empty, each an output of width 1, carrying the threshold flags.
REQ-015 The block SHALL have port count, output, width $clog2(DEPTH)+1, the current occupancy.
REQ-016 The block SHALL have ports overflow and underflow, each an output of width 1, as sticky error flags (present only per REQ-033).

Function
REQ-017 The block SHALL use first-word-fall-through reads: read_data equals the oldest stored word whenever fifo_empty==0 and all-zeros whenever fifo_empty==1.
REQ-018 A push SHALL be accepted on an edge where write_enable==1 and (fifo_full==0 or an accepted pop occurs on the same edge); the word is stored at wptr, wptr increments modulo DEPTH.
REQ-019 A pop SHALL be accepted on an edge where read_enable==1 and fifo_empty==0; rptr increments modulo DEPTH.
REQ-020 Count SHALL be +1 for a push only, -1 for a pop only, and unchanged for both or neither.
REQ-021 A simultaneous push and pop when full SHALL both be accepted: the head advances, the new word is stored, and count stays DEPTH.
REQ-022 A simultaneous push and pop when empty SHALL accept the push only and reject the pop (count becomes 1).
REQ-023 A push while full without a pop SHALL be dropped, leaving contents, pointers and count unchanged.
REQ-024 A pop while empty SHALL be ignored, leaving pointers and count unchanged.
REQ-025 All flags and count SHALL be registered or derived from registered count, reflecting an operation on the edge following it (zero-latency through-path excluded: a word written into an empty FIFO appears on read_data one cycle later).
REQ-026 Pointer wrap from DEPTH-1 to 0 SHALL be seamless, with no data loss or flag glitch.
REQ-027 Flush SHALL have priority over push and pop: on an edge where flush==1, pointers and count go to 0 and any concurrent push or pop is discarded.
REQ-028 Storage contents SHALL NOT be required to be cleared by reset or flush.

Reset
REQ-029 On n_rst==0 the block SHALL, asynchronously, set wptr=0, rptr=0, count=0, fifo_empty=1, fifo_full=0, almost_empty=1, almost_full=0, read_data=0, overflow=0 and underflow=0.
REQ-030 Reset asserted mid-operation SHALL abandon all stored words, and the first push after deassertion SHALL be read back first.

Configuration
REQ-031 When macro TX_FIFO_ERR_FLAGS_EN is defined, overflow SHALL set on any dropped push (REQ-023) and underflow SHALL set on any rejected pop (REQ-022, REQ-024).
REQ-032 When TX_FIFO_ERR_FLAGS_EN is defined, both flags SHALL hold until flush or reset, and flush clears them on the same edge.
REQ-033 Without TX_FIFO_ERR_FLAGS_EN, the overflow and underflow ports SHALL NOT exist and all other behaviour SHALL be identical.

Verification
REQ-034 Verification SHALL check, with defaults, that after reset 16 pushes of 0x01..0x10 give fifo_full=1, count=16 and almost_full=1 from count 14, and that 16 pops return 0x01..0x10 in order, ending with fifo_empty=1.
REQ-035 Verification SHALL check that while full, a push of 0xAA together with a pop gives count=16, the popped word equals the old head, and 0xAA is read out last.
REQ-036 Verification SHALL check that while empty, a push of 0x55 together with a pop gives count=1 next cycle with read_data=0x55; with the macro defined, underflow=1.
REQ-037 Verification SHALL check that an extra push of 0x77 while full (macro defined) leaves count=16 with overflow=1, 0x77 is never read, and a subsequent flush gives count=0, fifo_empty=1 and overflow=0.
REQ-038 Verification SHALL check that 40 random interleaved push and pop operations at DATA_WIDTH=12, DEPTH=4 (pointers wrapping at least 5 times) match a reference queue model cycle by cycle.
REQ-039 Verification SHALL check that asserting n_rst low mid-burst with count=7 immediately gives count=0 and fifo_empty=1, and that a subsequent push of 0x3C reads back 0x3C.
